// File: rtl/uart_rx_if.sv
// Serial-side bundle for the 8N1/8E1 UART receiver: line input plus byte, strobes and busy.
interface uart_rx_if;
    logic       uart_rx_i;
    logic [7:0] uart_rx_dat_o;
    logic       uart_rx_vld_o;
    logic       uart_rx_ferr_o;
    logic       uart_rx_perr_o;
    logic       uart_rx_busy_o;

    modport slave (
        input  uart_rx_i,
        output uart_rx_dat_o,
        output uart_rx_vld_o,
        output uart_rx_ferr_o,
        output uart_rx_perr_o,
        output uart_rx_busy_o
    );

    modport master (
        output uart_rx_i,
        input  uart_rx_dat_o,
        input  uart_rx_vld_o,
        input  uart_rx_ferr_o,
        input  uart_rx_perr_o,
        input  uart_rx_busy_o
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver, 16x oversampled with mid-bit sampling and phase-accumulator baud ticks.
// Define UART_RX_PARITY_EN for 8E1 frames with parity checking; default is 8N1.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | line idle, waiting for rx_s low
// START   | timing to mid start bit, rejects glitches
// DATA    | sampling 8 data bits LSB first at cnt=15
// PARITY  | sampling the even-parity bit (UART_RX_PARITY_EN only)
// STOP    | sampling the stop bit, emits vld or ferr
// BREAK   | framing error seen, waiting for the line to return high
module uart_rx #(
    parameter int CLK_HZ = 74000000,
    parameter int BAUD   = 115200
) (
    input  logic     sys_clk_i,
    input  logic     sys_rstn_i,
    uart_rx_if.slave rx_if
);

    localparam int          OVS     = 16 * BAUD;
    localparam logic [28:0] INC_POS = 29'(OVS);
    localparam logic [28:0] INC_NEG = 29'(OVS - CLK_HZ);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t      state_q;
    logic [1:0]  sync_q;
    logic [28:0] acc_q;
    logic [28:0] acc_d;
    logic [3:0]  cnt_q;
    logic [2:0]  bitidx_q;
    logic [7:0]  sh_q;
    logic [7:0]  dat_q;
    logic        vld_q;
    logic        ferr_q;
    logic        rx_s;
    logic        tick;
`ifdef UART_RX_PARITY_EN
    logic        par_q;
    logic        perr_q;
`endif

    assign rx_s = sync_q[1];
    assign tick = ~acc_q[28];

    // Signed accumulator: negative values mark the wait between ticks.
    always_comb begin
        acc_d = acc_q + (acc_q[28] ? INC_POS : INC_NEG);
    end

    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            sync_q   <= 2'b11;
            acc_q    <= '0;
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bitidx_q <= '0;
            sh_q     <= '0;
            dat_q    <= '0;
            vld_q    <= 1'b0;
            ferr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q    <= 1'b0;
            perr_q   <= 1'b0;
`endif
        end else begin
            sync_q <= {sync_q[0], rx_if.uart_rx_i};
            acc_q  <= acc_d;
            vld_q  <= 1'b0;
            ferr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q <= 1'b0;
`endif
            if (tick) begin
                case (state_q)
                    S_IDLE: begin
                        if (!rx_s) begin
                            state_q <= S_START;
                            cnt_q   <= '0;
                        end
                    end
                    S_START: begin
                        cnt_q <= cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            if (rx_s) begin
                                state_q <= S_IDLE;
                            end else begin
                                cnt_q    <= '0;
                                bitidx_q <= '0;
                                state_q  <= S_DATA;
                            end
                        end
                    end
                    S_DATA: begin
                        cnt_q <= cnt_q + 4'd1;
                        if (cnt_q == 4'd15) begin
                            sh_q <= {rx_s, sh_q[7:1]};
                            if (bitidx_q == 3'd7) begin
                                cnt_q   <= '0;
`ifdef UART_RX_PARITY_EN
                                state_q <= S_PARITY;
`else
                                state_q <= S_STOP;
`endif
                            end else begin
                                bitidx_q <= bitidx_q + 3'd1;
                            end
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    S_PARITY: begin
                        cnt_q <= cnt_q + 4'd1;
                        if (cnt_q == 4'd15) begin
                            par_q   <= rx_s;
                            cnt_q   <= '0;
                            state_q <= S_STOP;
                        end
                    end
`endif
                    S_STOP: begin
                        cnt_q <= cnt_q + 4'd1;
                        if (cnt_q == 4'd15) begin
                            if (rx_s) begin
                                dat_q   <= sh_q;
                                vld_q   <= 1'b1;
`ifdef UART_RX_PARITY_EN
                                perr_q  <= (^sh_q) ^ par_q;
`endif
                                state_q <= S_IDLE;
                            end else begin
                                ferr_q  <= 1'b1;
                                state_q <= S_BREAK;
                            end
                        end
                    end
                    S_BREAK: begin
                        if (rx_s) begin
                            state_q <= S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign rx_if.uart_rx_dat_o  = dat_q;
    assign rx_if.uart_rx_vld_o  = vld_q;
    assign rx_if.uart_rx_ferr_o = ferr_q;
    assign rx_if.uart_rx_busy_o = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign rx_if.uart_rx_perr_o = perr_q;
`else
    assign rx_if.uart_rx_perr_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table-driven frames plus hand-written corner sequences.
// Line rate is raised to 460800 baud (bit = 161 clocks at 74 MHz) to keep the run short.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int CLK_HZ   = 74000000;
    localparam int BAUD     = 460800;
    localparam int BIT      = 161;
    localparam int GLITCH   = 50;
    localparam int IDLE_MAX = 20 * BIT;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    int   vld_cnt      = 0;
    int   ferr_cnt     = 0;
    int   perr_vld_cnt = 0;
    int   perr_alone   = 0;
    logic [7:0] rx_q[$];

    uart_rx_if bus ();

    uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .sys_clk_i (clk),
        .sys_rstn_i(rst_n),
        .rx_if     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.uart_rx_vld_o) begin
                vld_cnt++;
                rx_q.push_back(bus.uart_rx_dat_o);
                if (bus.uart_rx_perr_o) perr_vld_cnt++;
            end
            if (bus.uart_rx_ferr_o) ferr_cnt++;
            if (bus.uart_rx_perr_o && !bus.uart_rx_vld_o) perr_alone++;
            if (bus.uart_rx_vld_o && bus.uart_rx_ferr_o) begin
                checks++;
                failures++;
                $display("FAIL vld_ferr_overlap: both strobes high at %0t, required never together", $time);
            end
        end
    end

    initial begin
        #(400000 * 10);
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    task automatic send_bit(input logic v, input int n);
        bus.uart_rx_i = v;
        repeat (n) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int stop_low, input logic par_flip);
        send_bit(1'b0, BIT);
        for (int i = 0; i < 8; i++) send_bit(d[i], BIT);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ par_flip, BIT);
`else
        if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
        if (stop_low > 0) send_bit(1'b0, stop_low * BIT);
        send_bit(1'b1, BIT);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (bus.uart_rx_busy_o && n < IDLE_MAX) begin
            @(negedge clk);
            n++;
        end
        check("busy_idle", int'(bus.uart_rx_busy_o), 0);
    endtask

    typedef struct {
        logic [7:0] data;
        int         stop_low;
        int         exp_vld;
        logic [7:0] exp_dat;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int b_vld, b_ferr, b_pv, b_q;

        vecs[0] = '{8'h55, 0, 1, 8'h55, 0};
        vecs[1] = '{8'hA5, 0, 1, 8'hA5, 0};
        vecs[2] = '{8'h3C, 5, 0, 8'hA5, 1};
        vecs[3] = '{8'h81, 0, 1, 8'h81, 0};
        vecs[4] = '{8'hFF, 0, 1, 8'hFF, 0};

        bus.uart_rx_i = 1'b1;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_dat",  int'(bus.uart_rx_dat_o),  0);
        check("rst_vld",  int'(bus.uart_rx_vld_o),  0);
        check("rst_ferr", int'(bus.uart_rx_ferr_o), 0);
        check("rst_perr", int'(bus.uart_rx_perr_o), 0);
        check("rst_busy", int'(bus.uart_rx_busy_o), 0);
        rst_n = 1'b1;
        send_bit(1'b1, 2 * BIT);

        for (int v = 0; v < 5; v++) begin
            b_vld  = vld_cnt;
            b_ferr = ferr_cnt;
            send_frame(vecs[v].data, vecs[v].stop_low, 1'b0);
            send_bit(1'b1, 2 * BIT);
            wait_idle();
            check($sformatf("vec%0d_vld", v),  vld_cnt - b_vld,  vecs[v].exp_vld);
            check($sformatf("vec%0d_dat", v),  int'(bus.uart_rx_dat_o), int'(vecs[v].exp_dat));
            check($sformatf("vec%0d_ferr", v), ferr_cnt - b_ferr, vecs[v].exp_ferr);
        end

        // back-to-back frames with no idle gap
        b_q = rx_q.size();
        send_frame(8'h00, 0, 1'b0);
        send_frame(8'hFF, 0, 1'b0);
        send_frame(8'hA5, 0, 1'b0);
        send_bit(1'b1, 2 * BIT);
        wait_idle();
        check("b2b_count", rx_q.size() - b_q, 3);
        if (rx_q.size() - b_q == 3) begin
            check("b2b_dat0", int'(rx_q[b_q]),     8'h00);
            check("b2b_dat1", int'(rx_q[b_q + 1]), 8'hFF);
            check("b2b_dat2", int'(rx_q[b_q + 2]), 8'hA5);
        end

        // short low pulse must be rejected at mid start bit
        b_vld  = vld_cnt;
        b_ferr = ferr_cnt;
        send_bit(1'b0, GLITCH);
        send_bit(1'b1, 2 * BIT);
        wait_idle();
        check("glitch_vld",  vld_cnt - b_vld,   0);
        check("glitch_ferr", ferr_cnt - b_ferr, 0);
        check("glitch_dat",  int'(bus.uart_rx_dat_o), 8'hA5);

        // reset during data bit 4 of 0xC3
        send_bit(1'b0, BIT);
        send_bit(1'b1, BIT);
        send_bit(1'b1, BIT);
        send_bit(1'b0, BIT);
        send_bit(1'b0, BIT);
        send_bit(1'b0, BIT / 2);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("mrst_dat",  int'(bus.uart_rx_dat_o),  0);
        check("mrst_vld",  int'(bus.uart_rx_vld_o),  0);
        check("mrst_ferr", int'(bus.uart_rx_ferr_o), 0);
        check("mrst_busy", int'(bus.uart_rx_busy_o), 0);
        bus.uart_rx_i = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        b_vld  = vld_cnt;
        b_ferr = ferr_cnt;
        send_bit(1'b1, BIT);
        send_frame(8'h12, 0, 1'b0);
        send_bit(1'b1, 2 * BIT);
        wait_idle();
        check("mrst_after_vld",  vld_cnt - b_vld,   1);
        check("mrst_after_dat",  int'(bus.uart_rx_dat_o), 8'h12);
        check("mrst_after_ferr", ferr_cnt - b_ferr, 0);

`ifdef UART_RX_PARITY_EN
        b_vld = vld_cnt;
        b_pv  = perr_vld_cnt;
        send_frame(8'h07, 0, 1'b0);
        send_bit(1'b1, 2 * BIT);
        wait_idle();
        check("par_good_vld",  vld_cnt - b_vld,    1);
        check("par_good_perr", perr_vld_cnt - b_pv, 0);
        b_vld = vld_cnt;
        b_pv  = perr_vld_cnt;
        send_frame(8'h07, 0, 1'b1);
        send_bit(1'b1, 2 * BIT);
        wait_idle();
        check("par_bad_vld",  vld_cnt - b_vld,    1);
        check("par_bad_perr", perr_vld_cnt - b_pv, 1);
        check("par_bad_dat",  int'(bus.uart_rx_dat_o), 8'h07);
`else
        b_pv = perr_vld_cnt;
        check("perr_tied_low", b_pv, 0);
`endif
        check("perr_without_vld", perr_alone, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
